// File: rtl/saturn_bus_ctrl.sv
// Saturn nibble-bus master: serialises one CPU transfer into
// command, address and data nibble slots.
module saturn_bus_ctrl #(
  parameter int SLOT_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic [1:0]  i_op,
  input  logic        i_load,
  input  logic [19:0] i_addr,
  input  logic [3:0]  i_len,
  input  logic [63:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [63:0] o_rdata,
  output logic        o_bus_clk_en,
  output logic        o_bus_is_data,
  output logic [3:0]  o_bus_nibble_out,
  input  logic [3:0]  i_bus_nibble_in
);

  localparam logic [3:0] BUSCMD_PC_READ  = 4'h0;
  localparam logic [3:0] BUSCMD_DP_READ  = 4'h1;
  localparam logic [3:0] BUSCMD_PC_WRITE = 4'h2;
  localparam logic [3:0] BUSCMD_DP_WRITE = 4'h3;
  localparam logic [3:0] BUSCMD_LOAD_PC  = 4'h4;
  localparam logic [3:0] BUSCMD_LOAD_DP  = 4'h5;

  localparam logic [3:0] LAST = 4'(SLOT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WCMD, XFER
  } state_t;

  state_t      state;
  logic [3:0]  phase;
  logic [1:0]  op;
  logic        load;
  logic [19:0] addr_sh;
  logic [3:0]  len;
  logic [63:0] wdata_sh;
  logic [2:0]  acnt;
  logic [3:0]  idx;
  logic        is_write;
  logic        is_dp;

  assign is_write = op[1];
  assign is_dp    = op[0];

  function automatic logic [3:0] cmd_of(
    input logic [1:0] o,
    input logic       ld
  );
    logic [3:0] c;
    c = BUSCMD_PC_READ;
    unique case (1'b1)
      ld && !o[0]:       c = BUSCMD_LOAD_PC;
      ld && o[0]:        c = BUSCMD_LOAD_DP;
      !ld && o == 2'b00: c = BUSCMD_PC_READ;
      !ld && o == 2'b01: c = BUSCMD_DP_READ;
      !ld && o == 2'b10: c = BUSCMD_PC_WRITE;
      !ld && o == 2'b11: c = BUSCMD_DP_WRITE;
    endcase
    return c;
  endfunction

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state            <= IDLE;
      phase            <= '0;
      op               <= '0;
      load             <= 1'b0;
      addr_sh          <= '0;
      len              <= '0;
      wdata_sh         <= '0;
      acnt             <= '0;
      idx              <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_rdata          <= '0;
      o_bus_clk_en     <= 1'b0;
      o_bus_is_data    <= 1'b0;
      o_bus_nibble_out <= '0;
    end else begin
      o_done <= 1'b0;
      if (state == IDLE) begin
        o_bus_clk_en <= 1'b0;
        if (i_req) begin
          op               <= i_op;
          load             <= i_load;
          addr_sh          <= i_addr;
          len              <= i_len;
          wdata_sh         <= i_wdata;
          if (!i_op[1])
            o_rdata <= '0;
          o_busy           <= 1'b1;
          phase            <= '0;
          state            <= CMD;
          o_bus_is_data    <= 1'b0;
          o_bus_nibble_out <= cmd_of(i_op, i_load);
        end
      end else begin
        o_bus_clk_en <= (phase == 4'd0);
        // slave drove its nibble on the strobe edge one cycle earlier
        if (state == XFER && !is_write && phase == 4'd2)
          o_rdata[{idx, 2'b00} +: 4] <= i_bus_nibble_in;
        if (phase != LAST) begin
          phase <= phase + 4'd1;
        end else begin
          phase <= '0;
          unique case (state)
            CMD: begin
              if (load) begin
                state            <= ADDR;
                acnt             <= '0;
                o_bus_is_data    <= 1'b1;
                o_bus_nibble_out <= addr_sh[3:0];
                addr_sh          <= addr_sh >> 4;
              end else begin
                state            <= XFER;
                idx              <= '0;
                o_bus_is_data    <= 1'b1;
                o_bus_nibble_out <= is_write ? wdata_sh[3:0] : 4'h0;
                wdata_sh         <= wdata_sh >> 4;
              end
            end
            ADDR: begin
              if (acnt != 3'd4) begin
                acnt             <= acnt + 3'd1;
                o_bus_nibble_out <= addr_sh[3:0];
                addr_sh          <= addr_sh >> 4;
              end else if (is_write) begin
                state            <= WCMD;
                o_bus_is_data    <= 1'b0;
                o_bus_nibble_out <= is_dp ? BUSCMD_DP_WRITE
                                          : BUSCMD_PC_WRITE;
              end else begin
                // slave auto-switches to read after the 5th nibble
                state            <= XFER;
                idx              <= '0;
                o_bus_nibble_out <= 4'h0;
              end
            end
            WCMD: begin
              state            <= XFER;
              idx              <= '0;
              o_bus_is_data    <= 1'b1;
              o_bus_nibble_out <= wdata_sh[3:0];
              wdata_sh         <= wdata_sh >> 4;
            end
            XFER: begin
              if (idx == len) begin
                state            <= IDLE;
                o_done           <= 1'b1;
                o_busy           <= 1'b0;
                o_bus_is_data    <= 1'b0;
                o_bus_nibble_out <= 4'h0;
              end else begin
                idx              <= idx + 4'd1;
                o_bus_nibble_out <= is_write ? wdata_sh[3:0] : 4'h0;
                wdata_sh         <= wdata_sh >> 4;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_saturn_bus_ctrl.sv
// Bench for saturn_bus_ctrl: slot-level reference model,
// nibble-bus slave with ROM, per-cycle compare.
module tb_saturn_bus_ctrl;

  localparam int P = 4;

  localparam logic [3:0] C_PC_READ  = 4'h0;
  localparam logic [3:0] C_DP_READ  = 4'h1;
  localparam logic [3:0] C_PC_WRITE = 4'h2;
  localparam logic [3:0] C_DP_WRITE = 4'h3;
  localparam logic [3:0] C_LOAD_PC  = 4'h4;
  localparam logic [3:0] C_LOAD_DP  = 4'h5;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req2;
  logic [1:0]  op;
  logic        load;
  logic [19:0] addr;
  logic [3:0]  len;
  logic [63:0] wdata;
  logic [3:0]  bus_in;

  logic        busy, done, cen, isd;
  logic [63:0] rdata;
  logic [3:0]  nib;

  logic        busy3, done3, cen3, isd3;
  logic [63:0] rdata3;
  logic [3:0]  nib3;
  logic        busy15, done15, cen15, isd15;
  logic [63:0] rdata15;
  logic [3:0]  nib15;

  always #5 clk = ~clk;

  saturn_bus_ctrl #(.SLOT_CYCLES(P)) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_op(op),
    .i_load(load), .i_addr(addr), .i_len(len), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_rdata(rdata),
    .o_bus_clk_en(cen), .o_bus_is_data(isd),
    .o_bus_nibble_out(nib), .i_bus_nibble_in(bus_in)
  );

  saturn_bus_ctrl #(.SLOT_CYCLES(3)) u3 (
    .i_clk(clk), .i_reset(rst), .i_req(req2), .i_op(op),
    .i_load(load), .i_addr(addr), .i_len(len), .i_wdata(wdata),
    .o_busy(busy3), .o_done(done3), .o_rdata(rdata3),
    .o_bus_clk_en(cen3), .o_bus_is_data(isd3),
    .o_bus_nibble_out(nib3), .i_bus_nibble_in(bus_in)
  );

  saturn_bus_ctrl #(.SLOT_CYCLES(15)) u15 (
    .i_clk(clk), .i_reset(rst), .i_req(req2), .i_op(op),
    .i_load(load), .i_addr(addr), .i_len(len), .i_wdata(wdata),
    .o_busy(busy15), .o_done(done15), .o_rdata(rdata15),
    .o_bus_clk_en(cen15), .o_bus_is_data(isd15),
    .o_bus_nibble_out(nib15), .i_bus_nibble_in(bus_in)
  );

  int checks = 0;
  int errors = 0;

  // ROM contents: address 0x12345 holds 1, 0x12346 holds 2, ...
  function automatic logic [3:0] rom(input logic [19:0] a);
    return 4'(a - 20'h12344);
  endfunction

  // Nibble-bus slave: tracks PC/DP from the command stream.
  logic [19:0] s_pc = '0;
  logic [19:0] s_dp = '0;
  logic        s_sel = 1'b0;
  int          s_mode = 0;
  int          s_acnt = 0;

  always @(posedge clk) begin
    if (cen) begin
      if (!isd) begin
        s_acnt = 0;
        case (nib)
          C_LOAD_PC:  begin s_mode = 1; s_sel = 1'b0; end
          C_LOAD_DP:  begin s_mode = 1; s_sel = 1'b1; end
          C_PC_READ:  begin s_mode = 2; s_sel = 1'b0; end
          C_DP_READ:  begin s_mode = 2; s_sel = 1'b1; end
          C_PC_WRITE: begin s_mode = 3; s_sel = 1'b0; end
          C_DP_WRITE: begin s_mode = 3; s_sel = 1'b1; end
          default:    s_mode = 0;
        endcase
      end else begin
        case (s_mode)
          1: begin
            if (s_sel) s_dp[4*s_acnt +: 4] = nib;
            else       s_pc[4*s_acnt +: 4] = nib;
            s_acnt++;
            if (s_acnt == 5) s_mode = 2;
          end
          2: begin
            bus_in <= rom(s_sel ? s_dp : s_pc);
            if (s_sel) s_dp = s_dp + 20'd1;
            else       s_pc = s_pc + 20'd1;
          end
          3: begin
            if (s_sel) s_dp = s_dp + 20'd1;
            else       s_pc = s_pc + 20'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Reference model: list of slots, expanded to per-cycle outputs.
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        cen;
    logic        isd;
    logic [3:0]  nib;
    logic        chk_rd;
    logic [63:0] rd;
  } exp_t;

  exp_t        q[$];
  logic        chk_idle = 1'b0;
  logic [19:0] m_pc = '0;
  logic [19:0] m_dp = '0;
  logic [63:0] m_rdata = '0;
  int          cyc = 0;

  function automatic logic [3:0] cmd_of(input logic [1:0] o);
    case (o)
      2'b00:   return C_PC_READ;
      2'b01:   return C_DP_READ;
      2'b10:   return C_PC_WRITE;
      default: return C_DP_WRITE;
    endcase
  endfunction

  task automatic build(input logic [1:0] o, input logic ld,
                       input logic [19:0] a, input logic [3:0] ln,
                       input logic [63:0] wd);
    logic [4:0]  sl[$];
    int          n;
    logic [19:0] base;
    logic [63:0] rd;
    exp_t        e;
    n = int'(ln) + 1;
    if (ld) sl.push_back({1'b0, o[0] ? C_LOAD_DP : C_LOAD_PC});
    else    sl.push_back({1'b0, cmd_of(o)});
    if (ld) begin
      for (int k = 0; k < 5; k++) sl.push_back({1'b1, a[4*k +: 4]});
      if (o[1]) sl.push_back({1'b0, o[0] ? C_DP_WRITE : C_PC_WRITE});
    end
    for (int k = 0; k < n; k++)
      sl.push_back({1'b1, o[1] ? wd[4*k +: 4] : 4'h0});
    base = ld ? a : (o[0] ? m_dp : m_pc);
    rd = m_rdata;
    if (!o[1]) begin
      rd = '0;
      for (int k = 0; k < n; k++) rd[4*k +: 4] = rom(base + 20'(k));
    end
    if (o[0]) m_dp = base + 20'(n);
    else      m_pc = base + 20'(n);
    for (int t = 0; t < sl.size() * P; t++) begin
      e.busy = 1'b1;
      e.done = 1'b0;
      e.cen = (t % P == 1);
      {e.isd, e.nib} = sl[t / P];
      e.chk_rd = o[1];
      e.rd = m_rdata;
      q.push_back(e);
    end
    e = '{busy: 1'b0, done: 1'b1, cen: 1'b0, isd: 1'b0,
          nib: 4'h0, chk_rd: 1'b1, rd: rd};
    q.push_back(e);
    m_rdata = rd;
  endtask

  task automatic compare(input exp_t e);
    checks++;
    if (busy !== e.busy || done !== e.done || cen !== e.cen ||
        isd !== e.isd || nib !== e.nib ||
        (e.chk_rd && rdata !== e.rd)) begin
      errors++;
      $display("FAIL cycle %0d: got busy=%b done=%b cen=%b isd=%b nib=%h rd=%h want busy=%b done=%b cen=%b isd=%b nib=%h rd=%h",
               cyc, busy, done, cen, isd, nib, rdata,
               e.busy, e.done, e.cen, e.isd, e.nib, e.rd);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      compare(e);
    end else if (chk_idle) begin
      e = '{busy: 1'b0, done: 1'b0, cen: 1'b0, isd: 1'b0,
            nib: 4'h0, chk_rd: 1'b1, rd: m_rdata};
      compare(e);
    end
  end

  logic [4:0] busrec[$];
  always @(negedge clk) if (cen) busrec.push_back({isd, nib});

  task automatic start(input logic [1:0] o, input logic ld,
                       input logic [19:0] a, input logic [3:0] ln,
                       input logic [63:0] wd);
    @(negedge clk);
    op = o; load = ld; addr = a; len = ln; wdata = wd;
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    build(o, ld, a, ln, wd);
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d expected cycles left", q.size());
      q.delete();
    end
  endtask

  task automatic run_lat(input logic [1:0] o, input logic ld,
                         input logic [19:0] a, input logic [3:0] ln,
                         input logic [63:0] wd, output int lat);
    busrec.delete();
    start(o, ld, a, ln, wd);
    lat = 0;
    @(negedge clk);
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    wait_done();
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic check_bus(input string nm, input logic [4:0] want[$]);
    check_int({nm, "_len"}, busrec.size(), want.size());
    for (int i = 0; i < want.size() && i < busrec.size(); i++) begin
      checks++;
      if (busrec[i] !== want[i]) begin
        errors++;
        $display("FAIL %s slot %0d: got %h want %h",
                 nm, i, busrec[i], want[i]);
      end
    end
  endtask

  function automatic bit pace_ok(input int p, input int t, input int s,
                                 input logic b, input logic d,
                                 input logic c, input logic i,
                                 input logic [3:0] n, input logic pi,
                                 input logic [3:0] pn);
    if (t < s * p)
      return b && !d && (c == (t % p == 1)) &&
             (t % p == 0 || (i == pi && n == pn));
    return !b && d && !c;
  endfunction

  initial begin
    int          lat;
    int          s3, s15;
    logic [19:0] save_pc;
    logic        pi3, pi15;
    logic [3:0]  pn3, pn15;
    logic [4:0]  exp_bus[$];

    rst = 1'b1; req = 1'b0; req2 = 1'b0;
    op = '0; load = 1'b0; addr = '0; len = '0; wdata = '0;
    #1;
    checks++;
    if (busy || done || cen || isd || nib != 4'h0 || rdata != '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b cen=%b nib=%h rd=%h",
               busy, done, cen, nib, rdata);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_idle = 1'b1;

    // read with load, ROM 1,2,3,4 at 0x12345
    run_lat(2'b00, 1'b1, 20'h12345, 4'd3, '0, lat);
    check_int("rd_load_latency", lat, 40);
    check_int("rd_load_data", int'(rdata[15:0]), 16'h4321);
    exp_bus = '{{1'b0, C_LOAD_PC}, 5'h15, 5'h14, 5'h13, 5'h12, 5'h11,
                5'h10, 5'h10, 5'h10, 5'h10};
    check_bus("rd_load_bus", exp_bus);

    // set PC to 0x1234E, then plain read returns A
    run_lat(2'b00, 1'b1, 20'h1234D, 4'd0, '0, lat);
    run_lat(2'b00, 1'b0, 20'h0, 4'd0, '0, lat);
    check_int("rd_plain_latency", lat, 8);
    check_int("rd_plain_data", int'(rdata[31:0]), 32'hA);
    exp_bus = '{{1'b0, C_PC_READ}, 5'h10};
    check_bus("rd_plain_bus", exp_bus);

    // write with load to DP
    run_lat(2'b11, 1'b1, 20'h00100, 4'd1, 64'hBA, lat);
    check_int("wr_load_latency", lat, 36);
    exp_bus = '{{1'b0, C_LOAD_DP}, 5'h10, 5'h10, 5'h11, 5'h10, 5'h10,
                {1'b0, C_DP_WRITE}, 5'h1A, 5'h1B};
    check_bus("wr_load_bus", exp_bus);

    // 16-nibble read with a request pulse while busy
    start(2'b00, 1'b1, 20'h20000, 4'd15, '0);
    repeat (9) @(negedge clk);
    op = 2'b10; load = 1'b0; len = 4'd2; wdata = 64'h123;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_done();
    check_int("len16_top_nibble", int'(rdata[63:60]),
              int'(rom(20'h2000F)));

    // reset during the ADDR phase
    save_pc = m_pc;
    start(2'b00, 1'b1, 20'hABCDE, 4'd2, '0);
    repeat (P + 1) @(negedge clk);
    #2;
    rst = 1'b1;
    chk_idle = 1'b0;
    q.delete();
    m_pc = save_pc;
    m_rdata = '0;
    #1;
    checks++;
    if (busy || done || cen || isd || nib != 4'h0 || rdata != '0) begin
      errors++;
      $display("FAIL reset_mid_addr: busy=%b done=%b cen=%b nib=%h rd=%h",
               busy, done, cen, nib, rdata);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done || busy || cen) begin
        errors++;
        $display("FAIL reset_hold: done=%b busy=%b cen=%b",
                 done, busy, cen);
      end
    end
    rst = 1'b0;
    chk_idle = 1'b1;
    run_lat(2'b00, 1'b0, 20'h0, 4'd0, '0, lat);
    check_int("after_reset_latency", lat, 8);

    // randomized transfers
    for (int i = 0; i < 40; i++) begin
      start(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            20'($urandom), 4'($urandom_range(0, 15)),
            {$urandom, $urandom});
      wait_done();
    end

    // strobe pacing at SLOT_CYCLES 3 and 15: write with load, 9 slots
    @(negedge clk);
    op = 2'b10; load = 1'b1; addr = 20'h5A5A5; len = 4'd1;
    wdata = 64'h7C;
    req2 = 1'b1;
    @(posedge clk);
    #1 req2 = 1'b0;
    s3 = 0; s15 = 0;
    pi3 = 1'b0; pn3 = '0; pi15 = 1'b0; pn15 = '0;
    for (int t = 0; t <= 9 * 15; t++) begin
      @(negedge clk);
      if (t <= 9 * 3) begin
        checks++;
        if (!pace_ok(3, t, 9, busy3, done3, cen3, isd3, nib3, pi3, pn3)) begin
          errors++;
          $display("FAIL pace3 t=%0d: busy=%b done=%b cen=%b isd=%b nib=%h",
                   t, busy3, done3, cen3, isd3, nib3);
        end
        if (cen3) s3++;
      end
      checks++;
      if (!pace_ok(15, t, 9, busy15, done15, cen15, isd15, nib15,
                   pi15, pn15)) begin
        errors++;
        $display("FAIL pace15 t=%0d: busy=%b done=%b cen=%b isd=%b nib=%h",
                 t, busy15, done15, cen15, isd15, nib15);
      end
      if (cen15) s15++;
      pi3 = isd3; pn3 = nib3; pi15 = isd15; pn15 = nib15;
    end
    check_int("pace3_strobes", s3, 9);
    check_int("pace15_strobes", s15, 9);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
